// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the Thunder RAM-port arbiter: slot width, FSM state
// encodings and access-length codes.
package mem_arbiter_pkg;

    localparam int LSB_CAP_BIT = 4;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_LOAD  = 2'd1,
        MA_STORE = 2'd2,
        MA_FETCH = 2'd3
    } ma_state_e;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Index of the final byte beat for a length code (n-1). The unused code 11
    // is treated as a word.
    function automatic logic [1:0] last_beat(input logic [1:0] len);
        case (len)
            LEN_BYTE: last_beat = 2'd0;
            LEN_HALF: last_beat = 2'd1;
            default:  last_beat = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer for mem_arbiter: holds the granted address/length/data,
// counts byte beats, presents the current beat address and store byte, and
// assembles little-endian load data.
module mem_arbiter_byte_seq
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  len_i,
    input  logic [31:0] val_i,
    input  logic [7:0]  mem_din,
    output logic [31:0] beat_addr_o,
    output logic [7:0]  beat_byte_o,
    output logic        last_o,
    output logic [31:0] word_o
);

    logic [31:0] addr_q;
    logic [31:0] val_q;
    logic [31:0] data_q;
    logic [1:0]  cnt_q;
    logic [1:0]  last_q;

    // Latch a new access on start; advance the beat and keep the assembled byte on step.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q <= '0;
            val_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else if (en_i) begin
            if (start_i) begin
                addr_q <= addr_i;
                val_q  <= val_i;
                data_q <= '0;
                cnt_q  <= '0;
                last_q <= last_beat(len_i);
            end else if (step_i) begin
                data_q <= word_o;
                cnt_q  <= cnt_q + 2'd1;
            end
        end
    end

    // Current beat address (wraps mod 2^32), store byte, and the word with
    // the incoming RAM byte merged into the current lane.
    always_comb begin
        beat_addr_o = addr_q + {30'd0, cnt_q};
        beat_byte_o = val_q[{cnt_q, 3'b000} +: 8];
        last_o      = (cnt_q == last_q);
        word_o      = data_q;
        word_o[{cnt_q, 3'b000} +: 8] = mem_din;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Thunder RAM-port arbiter: shares the byte-wide RAM between instruction
// fetch and the load/store buffer, splitting accesses into byte beats.
// Optional feature macro: MEM_ARB_IO_STALL_EN (stall stores to I/O space
// while io_buffer_full is high).
//
//  state    | meaning
//  MA_IDLE  | no access; grant a pending request
//  MA_LOAD  | LSB load, one byte per cycle
//  MA_STORE | LSB store, one byte per cycle (may stall on I/O)
//  MA_FETCH | instruction word fetch, four bytes
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h0003_0000,
    parameter bit          FAIR    = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic                   if_done,
    output logic [31:0]            if_data,
    input  logic                   lsb_req,
    input  logic [LSB_CAP_BIT-1:0] lsb_pos,
    input  logic                   lsb_ls,
    input  logic [1:0]             lsb_len,
    input  logic [31:0]            lsb_addr,
    input  logic [31:0]            lsb_val,
    output logic                   mem_busy,
    output logic                   mem_finished,
    output logic [31:0]            mem_val,
    output logic [LSB_CAP_BIT-1:0] mem_pos
);

    ma_state_e              state_q, state_d;
    logic                   last_lsb_q, last_lsb_d;
    logic [LSB_CAP_BIT-1:0] pos_q, pos_d;
    logic                   if_done_q, if_done_d;
    logic [31:0]            if_data_q, if_data_d;
    logic                   fin_q, fin_d;
    logic [31:0]            mem_val_q, mem_val_d;
    logic [LSB_CAP_BIT-1:0] mem_pos_q, mem_pos_d;

    logic        seq_start, seq_step, seq_last;
    logic [31:0] seq_addr, seq_val, seq_word, beat_addr;
    logic [1:0]  seq_len;
    logic [7:0]  beat_byte;
    logic        grant_fetch;
    logic        store_stall;

    mem_arbiter_byte_seq u_seq (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_i        (rdy_in),
        .start_i     (seq_start),
        .step_i      (seq_step),
        .addr_i      (seq_addr),
        .len_i       (seq_len),
        .val_i       (seq_val),
        .mem_din     (mem_din),
        .beat_addr_o (beat_addr),
        .beat_byte_o (beat_byte),
        .last_o      (seq_last),
        .word_o      (seq_word)
    );

`ifdef MEM_ARB_IO_STALL_EN
    assign store_stall = io_buffer_full && (beat_addr >= IO_BASE);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign store_stall    = 1'b0;
`endif

    // Fetch wins only when LSB is idle, or when fairness hands it the turn.
    assign grant_fetch = if_req && (!lsb_req || (FAIR && last_lsb_q));

    // Grant decision, beat sequencing and completion pulses.
    always_comb begin
        state_d    = state_q;
        last_lsb_d = last_lsb_q;
        pos_d      = pos_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        fin_d      = 1'b0;
        mem_val_d  = mem_val_q;
        mem_pos_d  = mem_pos_q;
        seq_start  = 1'b0;
        seq_step   = 1'b0;
        seq_addr   = lsb_addr;
        seq_len    = lsb_len;
        seq_val    = lsb_val;
        case (state_q)
            MA_IDLE: begin
                if (grant_fetch) begin
                    seq_addr   = if_addr;
                    seq_len    = LEN_WORD;
                    seq_val    = '0;
                    seq_start  = 1'b1;
                    state_d    = MA_FETCH;
                    last_lsb_d = 1'b0;
                end else if (lsb_req) begin
                    seq_start  = 1'b1;
                    state_d    = lsb_ls ? MA_STORE : MA_LOAD;
                    last_lsb_d = 1'b1;
                    pos_d      = lsb_pos;
                end
            end
            MA_LOAD: begin
                if (clear) begin
                    state_d = MA_IDLE;
                end else begin
                    seq_step = 1'b1;
                    if (seq_last) begin
                        state_d   = MA_IDLE;
                        fin_d     = 1'b1;
                        mem_val_d = seq_word;
                        mem_pos_d = pos_q;
                    end
                end
            end
            MA_FETCH: begin
                if (clear) begin
                    state_d = MA_IDLE;
                end else begin
                    seq_step = 1'b1;
                    if (seq_last) begin
                        state_d   = MA_IDLE;
                        if_done_d = 1'b1;
                        if_data_d = seq_word;
                    end
                end
            end
            MA_STORE: begin
                // Committed stores ignore clear and always finish.
                if (!store_stall) begin
                    seq_step = 1'b1;
                    if (seq_last) begin
                        state_d   = MA_IDLE;
                        fin_d     = 1'b1;
                        mem_pos_d = pos_q;
                    end
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    // State and output registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= MA_IDLE;
            last_lsb_q <= 1'b0;
            pos_q      <= '0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            fin_q      <= 1'b0;
            mem_val_q  <= '0;
            mem_pos_q  <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            last_lsb_q <= last_lsb_d;
            pos_q      <= pos_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            fin_q      <= fin_d;
            mem_val_q  <= mem_val_d;
            mem_pos_q  <= mem_pos_d;
        end
    end

    assign mem_a        = beat_addr;
    assign mem_dout     = beat_byte;
    assign mem_wr       = rdy_in && (state_q == MA_STORE) && !store_stall;
    assign mem_busy     = (state_q != MA_IDLE);
    assign if_done      = if_done_q;
    assign if_data      = if_data_q;
    assign mem_finished = fin_q;
    assign mem_val      = mem_val_q;
    assign mem_pos      = mem_pos_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM whose read data
// follows the driven address within the same beat cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic                   clk_in = 1'b0;
    logic                   rst_in, rdy_in, clear;
    logic [7:0]             mem_din, mem_dout;
    logic [31:0]            mem_a;
    logic                   mem_wr, io_buffer_full;
    logic                   if_req, if_done;
    logic [31:0]            if_addr, if_data;
    logic                   lsb_req, lsb_ls;
    logic [LSB_CAP_BIT-1:0] lsb_pos, mem_pos;
    logic [1:0]             lsb_len;
    logic [31:0]            lsb_addr, lsb_val, mem_val;
    logic                   mem_busy, mem_finished;

    int vec = 0;
    int miscmp = 0;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_val(lsb_val),
        .mem_busy(mem_busy), .mem_finished(mem_finished), .mem_val(mem_val),
        .mem_pos(mem_pos)
    );

    always #5 clk_in = ~clk_in;

    // RAM contents: 0x100..0x103 hold 11,22,33,44; elsewhere low address byte + 0x80.
    always_comb begin
        case (mem_a)
            32'h100: mem_din = 8'h11;
            32'h101: mem_din = 8'h22;
            32'h102: mem_din = 8'h33;
            32'h103: mem_din = 8'h44;
            default: mem_din = mem_a[7:0] + 8'h80;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic lsb_issue(input logic ls, input logic [1:0] len, input logic [31:0] addr,
                             input logic [31:0] val, input logic [LSB_CAP_BIT-1:0] pos);
        lsb_req  = 1'b1;
        lsb_ls   = ls;
        lsb_len  = len;
        lsb_addr = addr;
        lsb_val  = val;
        lsb_pos  = pos;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_ls = 1'b0; lsb_len = '0; lsb_addr = '0; lsb_val = '0; lsb_pos = '0;
        step(); step();
        rst_in = 1'b0;

        // Reset state
        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_a", mem_a, 32'd0);
        chk("rst_dout", 32'(mem_dout), 32'd0);
        chk("rst_done_fin", {30'd0, if_done, mem_finished}, 32'd0);
        chk("rst_vals", if_data | mem_val | 32'(mem_pos), 32'd0);

        // LW at 0x100, slot 5
        lsb_issue(1'b0, LEN_WORD, 32'h100, 32'h0, 4'd5);
        step(); lsb_req = 1'b0;
        chk("lw_busy", 32'(mem_busy), 32'd1);
        chk("lw_a0", mem_a, 32'h100);
        step();
        chk("lw_a1", mem_a, 32'h101);
        step(); step();
        chk("lw_a3", mem_a, 32'h103);
        chk("lw_nofin", 32'(mem_finished), 32'd0);
        step();
        chk("lw_fin", 32'(mem_finished), 32'd1);
        chk("lw_val", mem_val, 32'h4433_2211);
        chk("lw_pos", 32'(mem_pos), 32'd5);
        chk("lw_idle", 32'(mem_busy), 32'd0);
        step();
        chk("lw_pulse1", 32'(mem_finished), 32'd0);

        // SH 0xBEEF at 0x200, slot 3
        lsb_issue(1'b1, LEN_HALF, 32'h200, 32'h0000_BEEF, 4'd3);
        step(); lsb_req = 1'b0;
        chk("sh_b0", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0200, 8'h01, 8'hEF});
        step();
        chk("sh_b1", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0201, 8'h01, 8'hBE});
        step();
        chk("sh_fin", {30'd0, mem_wr, mem_finished}, 32'd1);
        chk("sh_pos", 32'(mem_pos), 32'd3);

        // Simultaneous fetch and LB; last grant was LSB so fetch goes first
        if_req = 1'b1; if_addr = 32'h40;
        lsb_issue(1'b0, LEN_BYTE, 32'h101, 32'h0, 4'd7);
        step();
        chk("arb_fetch_a0", mem_a, 32'h40);
        step(); step(); step();
        chk("arb_fetch_a3", mem_a, 32'h43);
        step();
        chk("arb_if_done", 32'(if_done), 32'd1);
        chk("arb_if_data", if_data, 32'hC3C2_C1C0);
        chk("arb_idle", 32'(mem_busy), 32'd0);
        if_req = 1'b0;
        step(); lsb_req = 1'b0;
        chk("arb_lsb_acc", {31'd0, mem_busy}, 32'd1);
        chk("arb_lsb_a", mem_a, 32'h101);
        chk("arb_done1", 32'(if_done), 32'd0);
        step();
        chk("arb_lb_fin", 32'(mem_finished), 32'd1);
        chk("arb_lb_val", mem_val, 32'h0000_0022);
        chk("arb_lb_pos", 32'(mem_pos), 32'd7);

        // Clear during LOAD at cnt=1
        lsb_issue(1'b0, LEN_WORD, 32'h100, 32'h0, 4'd2);
        step(); lsb_req = 1'b0;
        step();
        chk("clr_ld_a1", mem_a, 32'h101);
        clear = 1'b1;
        step(); clear = 1'b0;
        chk("clr_ld_idle", {30'd0, mem_busy, mem_finished}, 32'd0);
        step();
        chk("clr_ld_nofin", 32'(mem_finished), 32'd0);

        // Clear during STORE: both beats still written, then finished
        lsb_issue(1'b1, LEN_HALF, 32'h300, 32'h0000_1234, 4'd4);
        step(); lsb_req = 1'b0;
        chk("clr_st_b0", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0300, 8'h01, 8'h34});
        clear = 1'b1;
        step(); clear = 1'b0;
        chk("clr_st_b1", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0301, 8'h01, 8'h12});
        step();
        chk("clr_st_fin", 32'(mem_finished), 32'd1);
        chk("clr_st_pos", 32'(mem_pos), 32'd4);

        // SB to I/O space with io_buffer_full high for three cycles
        io_buffer_full = 1'b1;
        lsb_issue(1'b1, LEN_BYTE, 32'h0003_0000, 32'h0000_005A, 4'd1);
        step(); lsb_req = 1'b0;
`ifdef MEM_ARB_IO_STALL_EN
        chk("io_stall0", {31'd0, mem_wr}, 32'd0);
        step();
        chk("io_stall1", {31'd0, mem_wr}, 32'd0);
        step();
        chk("io_stall2", {30'd0, mem_wr, mem_finished}, 32'd0);
        io_buffer_full = 1'b0;
        #1;
        chk("io_write", {mem_a[23:0], mem_wr, mem_dout[6:0]}, {24'h03_0000, 1'b1, 7'h5A});
        step();
        chk("io_fin", {30'd0, mem_wr, mem_finished}, 32'd1);
`else
        chk("io_write", {mem_a[23:0], mem_wr, mem_dout[6:0]}, {24'h03_0000, 1'b1, 7'h5A});
        io_buffer_full = 1'b0;
        step();
        chk("io_fin", {30'd0, mem_wr, mem_finished}, 32'd1);
`endif

        // rdy_in low mid-store: write suppressed, state held
        lsb_issue(1'b1, LEN_BYTE, 32'h10, 32'h0000_0077, 4'd6);
        step(); lsb_req = 1'b0;
        chk("rdy_wr", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0010, 8'h01, 8'h77});
        rdy_in = 1'b0;
        #1;
        chk("rdy_wr_off", 32'(mem_wr), 32'd0);
        step();
        chk("rdy_hold", {30'd0, mem_busy, mem_finished}, 32'd2);
        rdy_in = 1'b1;
        #1;
        chk("rdy_resume", 32'(mem_wr), 32'd1);
        step();
        chk("rdy_fin", 32'(mem_finished), 32'd1);

        // Reset during a word store
        lsb_issue(1'b1, LEN_WORD, 32'h400, 32'hAABB_CCDD, 4'd9);
        step(); lsb_req = 1'b0;
        step();
        chk("rst_st_b1", {mem_a[15:0], 7'd0, mem_wr, mem_dout}, {16'h0401, 8'h01, 8'hCC});
        rst_in = 1'b1;
        step(); rst_in = 1'b0;
        chk("rst_st_out", {29'd0, mem_wr, mem_busy, mem_finished}, 32'd0);
        chk("rst_st_a", mem_a, 32'd0);
        chk("rst_st_vals", if_data | mem_val | 32'(mem_pos) | 32'(mem_dout), 32'd0);
        step();
        chk("rst_st_idle", {30'd0, mem_busy, mem_wr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
